ssd_scan_controller: RTL and testbench
======================================

Name: ssd_scan_controller

Overview:
- Scan controller for the 4-digit seven-segment display, fed by the UART receive path.
- Captures received bytes (rx_data/rx_valid pulse) into a two-byte nibble buffer and time-multiplexes the four digits at a prescaled refresh rate.
- Drives the digit select, the current nibble and the dash request to the downstream segment decoder.
- Reverts the display to dashes after an idle timeout with no received bytes.

Parameters:
- MAX_COUNT_SEL, 208_333, clk cycles per digit slot (50 MHz / (4 x 60 Hz)); must be >= 2.
- TIMEOUT_TICKS, 240, digit-slot ticks without rx_valid before all digits revert to dash; 0 disables the timeout.

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  asynchronous, active-high reset
- rx_data  input  8  received UART byte; sampled only when rx_valid=1
- rx_valid  input  1  single-cycle pulse, byte available on rx_data
- clear  input  1  synchronous clear of buffered data (active-high)
- dig_sel  output  4  one-hot digit enable; bit0 = rightmost digit
- digit_bits  output  4  nibble for the selected digit
- dash  output  1  1 = selected digit shows a dash instead of digit_bits
- data_valid  output  1  1 when any digit holds valid data

Behaviour:
- Reset (async, rst=1), all registers cleared immediately:
  - prescaler=0, idx=0, nib[0..3]=0, vld[3:0]=0, idle counter=0.
  - Outputs: dig_sel=4'b0001, digit_bits=0, dash=1, data_valid=0.
- Prescaler:
  - Counts 0..MAX_COUNT_SEL-1 and wraps to 0.
  - tick=1 in the cycle where count==MAX_COUNT_SEL-1.
  - On tick, idx <= (idx+1) mod 4, wrapping 3 -> 0.
- Outputs: registered every cycle from the current state, with one-cycle latency.
  - dig_sel <= one-hot(idx)
  - digit_bits <= nib[idx]
  - dash <= ~vld[idx]
  - data_valid <= |vld
  - A buffer update is therefore visible on the outputs in the cycle after the write.
- Byte capture (rx_valid=1, clear=0):
  - The older byte shifts up: nib[3] <= nib[1], nib[2] <= nib[0], vld[3:2] <= vld[1:0].
  - The new byte enters: nib[1] <= rx_data[7:4], nib[0] <= rx_data[3:0], vld[1:0] <= 2'b11.
  - The idle counter resets to 0.
  - Back-to-back rx_valid pulses are each captured; there is no overflow, and the oldest byte is discarded.
- Idle timeout (TIMEOUT_TICKS>0):
  - The idle counter increments on each tick and saturates at TIMEOUT_TICKS.
  - When the counter increments to TIMEOUT_TICKS, vld <= 4'b0000; nibble contents are retained but not shown.
  - Further ticks hold the counter at TIMEOUT_TICKS; there is no wrap.
  - When TIMEOUT_TICKS=0, the idle counter is held at 0 and vld is never cleared by timeout.
- Clear (clear=1): nib <= 0, vld <= 0, idle counter <= 0. The prescaler and idx are unaffected.
- Simultaneous events, in priority order:
  - clear beats rx_valid.
  - rx_valid beats a timeout expiring in the same cycle: the byte is captured and the counter goes to 0.
  - tick together with rx_valid: idx advances and the byte is captured, both in that cycle.
- Reset mid-scan or mid-timeout: everything returns immediately to reset values. The first tick after release occurs MAX_COUNT_SEL cycles after release.
- Scan rotation is continuous regardless of data state; there are no stalls.

Test Plan:
- Reset and idle rotation (MAX_COUNT_SEL=4): hold rst, release, no rx_valid.
  - Required: dig_sel cycles 0001 -> 0010 -> 0100 -> 1000 -> 0001, changing every 4 clk.
  - Required throughout: dash=1, data_valid=0.
- Single byte: pulse rx_valid with rx_data=8'hA5.
  - Required: data_valid=1 the next cycle.
  - Slot 0 shows digit_bits=5, dash=0; slot 1 shows digit_bits=A, dash=0.
  - Slots 2 and 3 show dash=1.
- Two bytes: pulse 8'h12, then 8'h34 (back-to-back cycles).
  - Required slot values: 0=4, 1=3, 2=2, 3=1, all with dash=0.
  - A third byte 8'h56 gives 6, 5, 4, 3.
- Timeout (TIMEOUT_TICKS=3): after byte 8'hA5, send no rx_valid.
  - Required: after the 3rd tick, all slots show dash=1 and data_valid=0.
  - A new byte 8'h0F restores slots 0 and 1 to F and 0.
- Priority checks:
  - clear and rx_valid(8'hFF) in the same cycle -> all dash, data_valid=0.
  - rx_valid in the cycle the timeout would expire -> byte shown, no dash on slots 0 and 1.
- Async reset mid-operation: with a full buffer, assert rst between clock edges.
  - Required: outputs go to dig_sel=0001, dash=1, digit_bits=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/ssd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_controller
// Description : Four-digit seven-segment scan controller. Captures UART bytes
//               into a two-byte nibble buffer and multiplexes the digits.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_controller #(
  parameter int MAX_COUNT_SEL = 208_333,
  parameter int TIMEOUT_TICKS = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clear,
  output logic [3:0] dig_sel,
  output logic [3:0] digit_bits,
  output logic       dash,
  output logic       data_valid
);

  localparam int CW = $clog2(MAX_COUNT_SEL);
  localparam int IW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(MAX_COUNT_SEL - 1);
  localparam logic [IW-1:0] C_IDLE_MAX = IW'(TIMEOUT_TICKS);
  localparam logic          C_TO_EN    = (TIMEOUT_TICKS > 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   nib_q, nib_d;
  logic [3:0]    vld_q, vld_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [3:0]    dig_sel_q, dig_sel_d;
  logic [3:0]    digit_bits_q, digit_bits_d;
  logic          dash_q, dash_d;
  logic          data_valid_q, data_valid_d;
  logic          w_tick;

  assign w_tick = (cnt_q == C_CNT_LAST);

  always_comb begin
    cnt_d  = w_tick ? '0 : cnt_q + CW'(1);
    idx_d  = w_tick ? idx_q + 2'd1 : idx_q;
    nib_d  = nib_q;
    vld_d  = vld_q;
    idle_d = idle_q;

    // Priority: clear, then byte capture, then idle timeout.
    if (clear) begin
      nib_d  = '0;
      vld_d  = '0;
      idle_d = '0;
    end else if (rx_valid) begin
      nib_d  = {nib_q[7:0], rx_data};
      vld_d  = {vld_q[1:0], 2'b11};
      idle_d = '0;
    end else if (C_TO_EN && w_tick && (idle_q != C_IDLE_MAX)) begin
      idle_d = idle_q + IW'(1);
      if (idle_d == C_IDLE_MAX) begin
        vld_d = '0;
      end
    end

    dig_sel_d    = 4'b0001 << idx_q;
    digit_bits_d = nib_q[{idx_q, 2'b00} +: 4];
    dash_d       = ~vld_q[idx_q];
    data_valid_d = |vld_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      nib_q        <= '0;
      vld_q        <= '0;
      idle_q       <= '0;
      dig_sel_q    <= 4'b0001;
      digit_bits_q <= '0;
      dash_q       <= 1'b1;
      data_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      nib_q        <= nib_d;
      vld_q        <= vld_d;
      idle_q       <= idle_d;
      dig_sel_q    <= dig_sel_d;
      digit_bits_q <= digit_bits_d;
      dash_q       <= dash_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign dig_sel    = dig_sel_q;
  assign digit_bits = digit_bits_q;
  assign dash       = dash_q;
  assign data_valid = data_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_controller
// Description : Self-checking bench for ssd_scan_controller (timeout off / on).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       clear;
  logic [3:0] dig_sel0, bits0, dig_sel1, bits1;
  logic       dash0, dv0, dash1, dv1;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  ssd_scan_controller #(.MAX_COUNT_SEL(4), .TIMEOUT_TICKS(0)) u_dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .clear(clear),
    .dig_sel(dig_sel0), .digit_bits(bits0), .dash(dash0), .data_valid(dv0)
  );

  ssd_scan_controller #(.MAX_COUNT_SEL(4), .TIMEOUT_TICKS(3)) u_dut_to (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .clear(clear),
    .dig_sel(dig_sel1), .digit_bits(bits1), .dash(dash1), .data_valid(dv1)
  );

  typedef struct packed {
    logic        clr;
    logic [1:0]  nb;
    logic [23:0] bytes;
    logic [15:0] nib;
    logic [3:0]  dsh;
    logic        dv;
  } vec_t;

  typedef struct packed {
    logic [3:0] tag;
    logic [1:0] slot;
    logic [3:0] bits;
    logic       dash;
    logic       dv;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[8];

  function automatic vec_t mk(input logic clr, input logic [1:0] nb, input logic [23:0] bytes,
                              input logic [15:0] nib, input logic [3:0] dsh, input logic dv);
    vec_t t;
    t.clr = clr; t.nb = nb; t.bytes = bytes; t.nib = nib; t.dsh = dsh; t.dv = dv;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 64 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: %0d slot checks never observed", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Waits for the timeout instance to advance to a new slot.
  task automatic sync_change(input string name);
    logic [3:0] prev;
    int i;
    prev = dig_sel1;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (dig_sel1 == prev && i < 20);
    if (dig_sel1 == prev) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: dig_sel stuck at %b", name, dig_sel1);
    end
  endtask

  task automatic sync_first(input string name);
    logic [3:0] prev;
    int i;
    i = 0;
    do begin
      prev = dig_sel1;
      @(negedge clk);
      i++;
    end while (!(dig_sel1 == 4'b0001 && prev != 4'b0001) && i < 40);
    if (!(dig_sel1 == 4'b0001 && prev != 4'b0001)) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: slot 0 entry not seen, dig_sel %b", name, dig_sel1);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0 && dig_sel0 == (4'b0001 << sb_q[0].slot)) begin
      exp_t e;
      e = sb_q.pop_front();
      check($sformatf("vec%0d_slot%0d {bits,dash,dv}", e.tag, e.slot),
            {bits0, dash0, dv0}, {e.bits, e.dash, e.dv});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ncyc;
    exp_t e;
    logic [3:0] exp_sel;

    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; clear = 1'b0;
    tbl[0] = mk(1'b0, 2'd0, 24'h000000, 16'h0000, 4'b1111, 1'b0);
    tbl[1] = mk(1'b0, 2'd1, 24'h0000A5, 16'h00A5, 4'b1100, 1'b1);
    tbl[2] = mk(1'b0, 2'd2, 24'h003412, 16'h1234, 4'b0000, 1'b1);
    tbl[3] = mk(1'b0, 2'd1, 24'h000056, 16'h3456, 4'b0000, 1'b1);
    tbl[4] = mk(1'b1, 2'd1, 24'h0000FF, 16'h0000, 4'b1111, 1'b0);
    tbl[5] = mk(1'b0, 2'd1, 24'h00009C, 16'h009C, 4'b1100, 1'b1);
    tbl[6] = mk(1'b0, 2'd3, 24'h452301, 16'h2345, 4'b0000, 1'b1);
    tbl[7] = mk(1'b1, 2'd0, 24'h000000, 16'h0000, 4'b1111, 1'b0);

    step(3);
    check("reset_dig_sel", dig_sel0, 4'b0001);
    check("reset_outs", {bits0, dash0, dv0, bits1, dash1, dv1}, {4'h0, 2'b10, 4'h0, 2'b10});
    rst = 1'b0;

    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_sel = 4'b0001 << (((k - 1) / 4) % 4);
      check($sformatf("rot_k%0d_dig_sel", k), dig_sel0, exp_sel);
      check($sformatf("rot_k%0d_dash_dv", k), {dash0, dv0, dash1, dv1}, 4'b1010);
    end

    for (int v = 0; v < 8; v++) begin
      ncyc = (tbl[v].nb != 2'd0) ? int'(tbl[v].nb) : int'(tbl[v].clr);
      for (int c = 0; c < ncyc; c++) begin
        clear    = tbl[v].clr && (c == 0);
        rx_valid = (c < int'(tbl[v].nb));
        rx_data  = tbl[v].bytes[8*c +: 8];
        @(negedge clk);
      end
      clear = 1'b0; rx_valid = 1'b0; rx_data = '0;
      @(negedge clk);
      for (int s = 0; s < 4; s++) begin
        e.tag  = 4'(v);
        e.slot = 2'(s);
        e.bits = tbl[v].nib[4*s +: 4];
        e.dash = tbl[v].dsh[s];
        e.dv   = tbl[v].dv;
        sb_q.push_back(e);
      end
      drain($sformatf("vec%0d_drain", v));
    end

    // Full buffer, then asynchronous reset between clock edges.
    rx_valid = 1'b1; rx_data = 8'h11; step(1);
    rx_data = 8'h22; step(1);
    rx_valid = 1'b0; step(1);
    for (int i = 0; i < 20 && dig_sel0 == 4'b0001; i++) @(negedge clk);
    check("pre_reset_dash_dv", {dash0, dv0}, 2'b01);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dig_sel", dig_sel0, 4'b0001);
    check("async_rst_outs", {bits0, dash0, dv0, dig_sel1, bits1, dash1, dv1},
          {4'h0, 2'b10, 4'b0001, 4'h0, 2'b10});
    @(negedge clk);
    rst = 1'b0;
    step(4);
    check("post_rst_no_early_tick", dig_sel0, 4'b0001);
    step(1);
    check("post_rst_first_tick", dig_sel0, 4'b0010);

    // Timeout expiry on the TIMEOUT_TICKS=3 instance.
    sync_change("t1_sync");
    rx_valid = 1'b1; rx_data = 8'hA5; step(1);
    rx_valid = 1'b0; step(10);
    check("t1_before_expiry_dv", dv1, 1'b1);
    step(1);
    check("t1_expired {dv,dash,dv_notimeout}", {dv1, dash1, dv0}, 3'b011);

    // New byte restores slots 0 and 1.
    sync_first("t2_sync");
    rx_valid = 1'b1; rx_data = 8'h0F; step(1);
    rx_valid = 1'b0; step(1);
    check("t2_slot0 {sel,bits,dash,dv}", {dig_sel1, bits1, dash1, dv1}, {4'b0001, 4'hF, 2'b01});
    step(3);
    check("t2_slot1 {sel,bits,dash,dv}", {dig_sel1, bits1, dash1, dv1}, {4'b0010, 4'h0, 2'b01});

    // Byte arriving on the expiring tick wins and restarts the idle count.
    sync_change("t3_sync");
    rx_valid = 1'b1; rx_data = 8'h77; step(1);
    rx_valid = 1'b0; step(9);
    rx_valid = 1'b1; rx_data = 8'h88; step(1);
    rx_valid = 1'b0; step(1);
    check("t3_race {dv,dash}", {dv1, dash1}, 2'b10);
    step(11);
    check("t3_restart_before_expiry_dv", dv1, 1'b1);
    step(1);
    check("t3_restart_expired {dv,dash}", {dv1, dash1}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
